// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with ACK + 40-bit frame.
// Latency: acknowledge low RESPONSE_DELAY_US us + 3 cycles after host release; frame timing fixed in us.
// Backpressure: none; a host pulling the line low during a released phase aborts the frame (collision).
// Ports: clock/reset_n (async active-low); transmission_line open-drain (0 or z);
//        humidity_*/temperature_* payload bytes; mute, corrupt_checksum fault inputs;
//        drive_low, busy, frame_done (pulse), collision (pulse) status outputs.
module dht11_responder #(
  parameter int CLOCK_FREQ_MHZ    = 50,
  parameter int START_MIN_US      = 1000,
  parameter int RESPONSE_DELAY_US = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  inout  wire        transmission_line,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temperature_int,
  input  logic [7:0] temperature_dec,
  input  logic       mute,
  input  logic       corrupt_checksum,
  output logic       drive_low,
  output logic       busy,
  output logic       frame_done,
  output logic       collision
);

  localparam int PRE_W = (CLOCK_FREQ_MHZ > 1) ? $clog2(CLOCK_FREQ_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCK_FREQ_MHZ - 1);

  // Phase lengths are held as "last us index" so the phase ends on the final
  // prescaler tick of that microsecond: N us == N*CLOCK_FREQ_MHZ cycles.
  localparam logic [15:0] START_MIN     = 16'(START_MIN_US);
  localparam logic [15:0] RESP_LAST     = 16'(RESPONSE_DELAY_US - 1);
  localparam logic [15:0] ACK_LAST      = 16'd79;
  localparam logic [15:0] LOW50_LAST    = 16'd49;
  localparam logic [15:0] ZERO_HI_LAST  = 16'd25;
  localparam logic [15:0] ONE_HI_LAST   = 16'd69;
  // Released phases ignore the line for 2 us: pull-up rise plus synchronizer.
  localparam logic [15:0] GUARD_US      = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_RESP_DELAY,
    S_ACK_LOW,
    S_ACK_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  state_t           state;
  logic             line_meta;
  logic             line_s;
  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      us_cnt;
  logic [5:0]       bit_idx;
  logic [39:0]      frame_sr;

  logic        us_tick;
  logic [15:0] phase_last;
  logic        phase_end;
  logic        start_ok;
  logic        released_phase;
  logic        collide;
  logic [7:0]  snap_sum;
  logic [7:0]  snap_chk;

  // Open-drain: the responder never drives a 1.
  assign transmission_line = drive_low ? 1'b0 : 1'bz;

  assign us_tick = (pre_cnt == PRE_LAST);

  always_comb begin
    phase_last = 16'hFFFF;
    case (state)
      S_RESP_DELAY:         phase_last = RESP_LAST;
      S_ACK_LOW, S_ACK_HIGH: phase_last = ACK_LAST;
      S_BIT_LOW, S_END_LOW: phase_last = LOW50_LAST;
      S_BIT_HIGH:           phase_last = frame_sr[39] ? ONE_HI_LAST : ZERO_HI_LAST;
      default:              phase_last = 16'hFFFF;
    endcase
  end

  assign phase_end = us_tick && (us_cnt == phase_last);

  // A release landing on the very tick that completes START_MIN_US is accepted.
  assign start_ok = (us_cnt >= START_MIN) || (us_tick && (us_cnt == START_MIN - 16'd1));

  assign released_phase = (state == S_RESP_DELAY) || (state == S_ACK_HIGH) ||
                          (state == S_BIT_HIGH);
  assign collide        = released_phase && (us_cnt >= GUARD_US) && !line_s;

  assign snap_sum = humidity_int + humidity_dec + temperature_int + temperature_dec;
  assign snap_chk = snap_sum ^ {7'd0, corrupt_checksum};

  // Every state entry restarts the us prescaler; drive_low follows the new state.
  task automatic enter(input state_t nxt);
    state     <= nxt;
    pre_cnt   <= '0;
    us_cnt    <= '0;
    drive_low <= (nxt == S_ACK_LOW) || (nxt == S_BIT_LOW) || (nxt == S_END_LOW);
  endtask

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      line_meta  <= 1'b1;
      line_s     <= 1'b1;
      pre_cnt    <= '0;
      us_cnt     <= '0;
      bit_idx    <= '0;
      frame_sr   <= '0;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      collision  <= 1'b0;
    end else begin
      line_meta  <= transmission_line;
      line_s     <= line_meta;
      frame_done <= 1'b0;
      collision  <= 1'b0;

      if (us_tick) begin
        pre_cnt <= '0;
        if (us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end

      case (state)
        // Right after END_LOW the synchronizer still holds our own low for two
        // cycles; that echo enters START_LOW and falls back as a short glitch.
        S_IDLE: begin
          if (!line_s && !mute) enter(S_START_LOW);
        end

        S_START_LOW: begin
          if (line_s) begin
            if (start_ok) begin
              enter(S_RESP_DELAY);
              frame_sr <= {humidity_int, humidity_dec, temperature_int,
                           temperature_dec, snap_chk};
              busy     <= 1'b1;
              bit_idx  <= '0;
            end else begin
              enter(S_IDLE);
            end
          end
        end

        S_RESP_DELAY, S_ACK_HIGH: begin
          if (collide) begin
            collision <= 1'b1;
            busy      <= 1'b0;
            enter(S_IDLE);
          end else if (phase_end) begin
            enter(state == S_RESP_DELAY ? S_ACK_LOW : S_BIT_LOW);
          end
        end

        S_ACK_LOW: begin
          if (phase_end) enter(S_ACK_HIGH);
        end

        S_BIT_LOW: begin
          if (phase_end) enter(S_BIT_HIGH);
        end

        S_BIT_HIGH: begin
          if (collide) begin
            collision <= 1'b1;
            busy      <= 1'b0;
            enter(S_IDLE);
          end else if (phase_end) begin
            frame_sr <= {frame_sr[38:0], 1'b0};
            if (bit_idx < 6'd39) begin
              bit_idx <= bit_idx + 6'd1;
              enter(S_BIT_LOW);
            end else begin
              enter(S_END_LOW);
            end
          end
        end

        S_END_LOW: begin
          if (phase_end) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            enter(S_IDLE);
          end
        end

        default: enter(S_IDLE);
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: host-side model driving start pulses and decoding the responder's frames.
// Latency: checks acknowledge latency and every phase length in clock cycles.
// Backpressure: host injects collisions by pulling the shared line low.
module tb_dht11_responder;

  localparam int F        = 2;    // clock cycles per us
  localparam int MIN_US   = 100;  // scaled start threshold
  localparam int RESP_US  = 30;
  localparam int START_US = 180;  // scaled "18 ms" start
  localparam int GLITCH_US = 40;

  logic       clock;
  logic       reset_n;
  logic       host_low;
  wire        line;
  logic [7:0] hum_i, hum_d, tmp_i, tmp_d;
  logic       mute, corrupt;
  logic       drive_low, busy, frame_done, collision;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_cnt       = 0;
  int col_cnt      = 0;

  logic [39:0] exp_q[$];

  assign line = host_low ? 1'b0 : 1'bz;
  pullup (line);

  dht11_responder #(
    .CLOCK_FREQ_MHZ   (F),
    .START_MIN_US     (MIN_US),
    .RESPONSE_DELAY_US(RESP_US)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .transmission_line(line),
    .humidity_int     (hum_i),
    .humidity_dec     (hum_d),
    .temperature_int  (tmp_i),
    .temperature_dec  (tmp_d),
    .mute             (mute),
    .corrupt_checksum (corrupt),
    .drive_low        (drive_low),
    .busy             (busy),
    .frame_done       (frame_done),
    .collision        (collision)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (collision === 1'b1) col_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic cor);
    hum_i = a; hum_d = b; tmp_i = c; tmp_d = d; corrupt = cor;
  endtask

  // Pull the line low for 'us' microseconds, releasing 1 ns after a rising edge.
  task automatic host_start(input int us);
    @(posedge clock); #1 host_low = 1'b1;
    repeat (us * F) @(posedge clock);
    #1 host_low = 1'b0;
  endtask

  // Count cycles (negedge samples) while drive_low holds 'val'; exits on the
  // first sample of the next phase.
  task automatic run_len(input logic val, output int len, inout bit busy_ok);
    len = 0;
    while (drive_low === val && len < 5000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      len++;
      @(negedge clock);
    end
  endtask

  // Watch 'cycles' cycles for any drive or busy activity.
  task automatic quiet_window(input int cycles, output bit drove, output bit was_busy);
    drove = 1'b0; was_busy = 1'b0;
    repeat (cycles) begin
      @(negedge clock);
      if (drive_low !== 1'b0) drove = 1'b1;
      if (busy !== 1'b0) was_busy = 1'b1;
    end
  endtask

  // Scoreboard consumer: called right after host release, pops the expected frame.
  task automatic capture_frame();
    logic [39:0] exp_f, got;
    int lat, len, fd0, want;
    bit busy_ok;
    busy_ok = 1'b1;
    got = '0;
    fd0 = fd_cnt;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
      return;
    end
    exp_f = exp_q.pop_front();
    lat = 0;
    while (drive_low !== 1'b1 && lat < 2000) begin
      @(posedge clock); #1;
      lat++;
    end
    tests_run++;
    if (lat !== RESP_US * F + 3) begin
      tests_failed++;
      $display("FAIL ack_latency: got %0d cycles required %0d", lat, RESP_US * F + 3);
    end
    @(negedge clock);
    run_len(1'b1, len, busy_ok);
    tests_run++;
    if (len !== 80 * F) begin
      tests_failed++;
      $display("FAIL ack_low_len: got %0d required %0d", len, 80 * F);
    end
    run_len(1'b0, len, busy_ok);
    tests_run++;
    if (len !== 80 * F) begin
      tests_failed++;
      $display("FAIL ack_high_len: got %0d required %0d", len, 80 * F);
    end
    for (int i = 0; i < 40; i++) begin
      run_len(1'b1, len, busy_ok);
      tests_run++;
      if (len !== 50 * F) begin
        tests_failed++;
        $display("FAIL bit%0d_low_len: got %0d required %0d", i, len, 50 * F);
      end
      run_len(1'b0, len, busy_ok);
      got  = {got[38:0], (len > 48 * F)};
      want = exp_f[39 - i] ? 70 * F : 26 * F;
      tests_run++;
      if (len !== want) begin
        tests_failed++;
        $display("FAIL bit%0d_high_len: got %0d required %0d", i, len, want);
      end
      if (i == 39) break;
    end
    // The last released run ends when END_LOW starts; measure END_LOW next.
    run_len(1'b1, len, busy_ok);
    tests_run++;
    if (len !== 50 * F) begin
      tests_failed++;
      $display("FAIL end_low_len: got %0d required %0d", len, 50 * F);
    end
    tests_run++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_end_flags: got done=%b busy=%b required done=1 busy=0",
               frame_done, busy);
    end
    tests_run++;
    if (got !== exp_f) begin
      tests_failed++;
      $display("FAIL frame_data: got %h required %h", got, exp_f);
    end
    tests_run++;
    if (!busy_ok) begin
      tests_failed++;
      $display("FAIL busy_cover: got busy low during frame required high");
    end
    repeat (4) @(negedge clock);
    tests_run++;
    if (fd_cnt - fd0 !== 1) begin
      tests_failed++;
      $display("FAIL frame_done_count: got %0d required 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; host_low = 1'b0; mute = 1'b0;
    load(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (drive_low !== 1'b0) begin tests_failed++; $display("FAIL reset_drive_low: got %b required 0", drive_low); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    tests_run++;
    if (collision !== 1'b0) begin tests_failed++; $display("FAIL reset_collision: got %b required 0", collision); end
    tests_run++;
    if (line !== 1'b1) begin tests_failed++; $display("FAIL reset_line: got %b required 1", line); end
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
  endtask

  task automatic test_basic();
    load(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    exp_q.push_back(40'h37_00_19_00_50);
    host_start(START_US);
    capture_frame();
  endtask

  task automatic test_glitch();
    bit drove, was_busy;
    load(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
    host_start(GLITCH_US);
    quiet_window(400, drove, was_busy);
    tests_run++;
    if (drove || was_busy) begin
      tests_failed++;
      $display("FAIL glitch_ignored: got drove=%b busy=%b required 0 0", drove, was_busy);
    end
    exp_q.push_back(40'hFF_FF_01_02_01);
    host_start(START_US);
    capture_frame();
  endtask

  task automatic test_mute();
    bit drove, was_busy;
    mute = 1'b1;
    host_start(START_US);
    quiet_window(400, drove, was_busy);
    tests_run++;
    if (drove || was_busy) begin
      tests_failed++;
      $display("FAIL mute_silent: got drove=%b busy=%b required 0 0", drove, was_busy);
    end
    mute = 1'b0;
    repeat (5) @(posedge clock);
    load(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1);
    exp_q.push_back(40'hFF_FF_01_02_00);
    host_start(START_US);
    fork
      capture_frame();
      begin
        repeat (1500) @(posedge clock);
        mute = 1'b1;
      end
    join
    mute = 1'b0;
    corrupt = 1'b0;
  endtask

  task automatic test_collision();
    int lat, len, col0, fd0;
    bit busy_ok, drove, was_busy, seen;
    load(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    host_start(START_US);
    lat = 0;
    while (drive_low !== 1'b1 && lat < 2000) begin
      @(posedge clock); #1;
      lat++;
    end
    @(negedge clock);
    busy_ok = 1'b1;
    run_len(1'b1, len, busy_ok);          // through ACK_LOW
    repeat (10 * F) @(negedge clock);     // 10 us into ACK_HIGH
    col0 = col_cnt; fd0 = fd_cnt;
    host_low = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (collision === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL collision_pulse: got 0 required 1 within 10 cycles"); end
    repeat (2) @(negedge clock);
    host_low = 1'b0;
    quiet_window(300, drove, was_busy);
    tests_run++;
    if (drove || was_busy) begin
      tests_failed++;
      $display("FAIL collision_release: got drove=%b busy=%b required 0 0", drove, was_busy);
    end
    tests_run++;
    if (col_cnt - col0 !== 1) begin tests_failed++; $display("FAIL collision_count: got %0d required 1", col_cnt - col0); end
    tests_run++;
    if (fd_cnt - fd0 !== 0) begin tests_failed++; $display("FAIL collision_no_done: got %0d required 0", fd_cnt - fd0); end
  endtask

  // Follows a collision; payload and fault inputs change during bit 5.
  task automatic test_payload_change();
    load(8'hA5, 8'h3C, 8'h7E, 8'h81, 1'b0);
    exp_q.push_back(40'hA5_3C_7E_81_E0);
    host_start(START_US);
    fork
      capture_frame();
      begin
        repeat (1330) @(posedge clock);
        load(8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1);
      end
    join
    corrupt = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int lat, len;
    bit busy_ok, drove, was_busy;
    load(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    host_start(START_US);
    lat = 0;
    while (drive_low !== 1'b1 && lat < 2000) begin
      @(posedge clock); #1;
      lat++;
    end
    @(negedge clock);
    busy_ok = 1'b1;
    run_len(1'b1, len, busy_ok);
    run_len(1'b0, len, busy_ok);
    for (int i = 0; i < 12; i++) begin
      run_len(1'b1, len, busy_ok);
      run_len(1'b0, len, busy_ok);
    end
    repeat (10) @(negedge clock);         // inside BIT_LOW of bit 12
    tests_run++;
    if (drive_low !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bit12_low_active: got drive=%b busy=%b required 1 1", drive_low, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (drive_low !== 1'b0 || line !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_release: got drive=%b line=%b required 0 1", drive_low, line);
    end
    tests_run++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || collision !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_outputs: got busy=%b done=%b col=%b required 0 0 0",
               busy, frame_done, collision);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    quiet_window(300, drove, was_busy);
    tests_run++;
    if (drove || was_busy) begin
      tests_failed++;
      $display("FAIL reset_discard: got drove=%b busy=%b required 0 0", drove, was_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_mute();
    test_collision();
    test_payload_change();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
